// File: rtl/ysyx_22040386_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22040386_seq_ctrl
//
// Multi-cycle sequencer for the ysyx_22040386 core. An instruction is
// fetched over a valid/ready handshake with instruction memory, decoded,
// executed, optionally sent to data memory over a second valid/ready
// handshake, and committed in a single write-back cycle. The block also
// counts retired instructions and supports a terminal halt state.
//
// State encodings (exported on `state`):
//   FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 ERR=6
//
// Ports:
//   clk           core clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   imem_valid    fetch request (high for the whole of FETCH)
//   imem_ready    instruction word present this cycle (FETCH only)
//   ir_we         latch the instruction word (FETCH & imem_ready)
//   dec_load      decoded instruction is a load
//   dec_store     decoded instruction is a store
//   dec_regwrite  decoded instruction writes rd
//   dec_branch    next PC is dnpc
//   halt_req      decoded instruction is ebreak (sampled in DECODE)
//   dmem_valid    data access request (high for the whole of MEM)
//   dmem_wen      data access is a write
//   dmem_ready    data access complete (MEM only)
//   pc_we         PC update strobe (WB)
//   pc_sel        0 = snpc, 1 = dnpc
//   reg_we        register-file write strobe (WB)
//   state         current FSM state encoding
//   halted        sticky halt flag
//   err           sticky timeout flag
//   instret       64-bit retired-instruction counter
//
// Optional feature: define YSYX_22040386_SEQ_TIMEOUT_EN to bound each
// memory handshake to TIMEOUT_CYCLES wait cycles (1..255); an expired wait
// moves the FSM to the terminal ERR state. Without the macro, waits are
// unbounded and err is tied low.
// ---------------------------------------------------------------------------
module ysyx_22040386_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_valid,
  input  logic        imem_ready,
  output logic        ir_we,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_regwrite,
  input  logic        dec_branch,
  input  logic        halt_req,
  output logic        dmem_valid,
  output logic        dmem_wen,
  input  logic        dmem_ready,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        err,
  output logic [63:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]  state_reg;
  logic [2:0]  state_next;
  logic [63:0] instret_reg;
  logic        timeout_hit;

  // -------------------------------------------------------------------------
  // Handshake timeout
  // -------------------------------------------------------------------------
`ifdef YSYX_22040386_SEQ_TIMEOUT_EN
  // wait_cnt_reg holds the number of wait cycles already spent in the
  // current FETCH/MEM visit. The cycle that would bring it to
  // TIMEOUT_CYCLES with ready still low is the last one tolerated; a ready
  // in that cycle is simply a normal completion.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt_reg;
  logic       waiting;

  assign waiting = ((state_reg == S_FETCH) && !imem_ready) ||
                   ((state_reg == S_MEM)   && !dmem_ready);
  assign timeout_hit = waiting && (wait_cnt_reg == WAIT_LAST);

  // Any non-waiting cycle clears the counter, so every entry into FETCH or
  // MEM starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if (waiting) begin
      wait_cnt_reg <= wait_cnt_reg + 8'd1;
    end else begin
      wait_cnt_reg <= '0;
    end
  end
`else
  logic [7:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 8'(TIMEOUT_CYCLES);
  assign timeout_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: begin
        if (imem_ready) begin
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end
      end
      S_DECODE: state_next = halt_req ? S_HALT : S_EXEC;
      S_EXEC:   state_next = (dec_load || dec_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ready) begin
          state_next = S_WB;
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end
      end
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      S_ERR:    state_next = S_ERR;
      // Unused encoding 7: recover by refetching.
      default:  state_next = S_FETCH;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and retired-instruction counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      // WB always lasts exactly one cycle, so this counts each commit once;
      // the natural 64-bit overflow gives the required wrap to zero.
      if (state_reg == S_WB) begin
        instret_reg <= instret_reg + 64'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from the current state (Moore) except ir_we, which
  // must fire in the same cycle imem_ready is seen.
  // -------------------------------------------------------------------------
  always_comb begin
    imem_valid = 1'b0;
    ir_we      = 1'b0;
    dmem_valid = 1'b0;
    dmem_wen   = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    reg_we     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_valid = 1'b1;
        ir_we      = imem_ready;
      end
      S_MEM: begin
        dmem_valid = 1'b1;
        dmem_wen   = dec_store;
      end
      S_WB: begin
        pc_we  = 1'b1;
        pc_sel = dec_branch;
        // A store never writes rd even if the decoder flags it.
        reg_we = dec_regwrite & ~dec_store;
      end
      default: begin
      end
    endcase
  end

  assign state   = state_reg;
  assign instret = instret_reg;
  // HALT and ERR are terminal until reset, so flags derived from the state
  // are sticky by construction.
  assign halted  = (state_reg == S_HALT);
`ifdef YSYX_22040386_SEQ_TIMEOUT_EN
  assign err     = (state_reg == S_ERR);
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22040386_seq_ctrl.sv
// Directed testbench for ysyx_22040386_seq_ctrl. Inputs change 1 ns after
// each rising edge; outputs are sampled 1 ns later, well away from the edge.
module tb_ysyx_22040386_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_valid;
  logic        imem_ready;
  logic        ir_we;
  logic        dec_load;
  logic        dec_store;
  logic        dec_regwrite;
  logic        dec_branch;
  logic        halt_req;
  logic        dmem_valid;
  logic        dmem_wen;
  logic        dmem_ready;
  logic        pc_we;
  logic        pc_sel;
  logic        reg_we;
  logic [2:0]  state;
  logic        halted;
  logic        err;
  logic [63:0] instret;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_instret = 64'd0;

  ysyx_22040386_seq_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_valid   (imem_valid),
    .imem_ready   (imem_ready),
    .ir_we        (ir_we),
    .dec_load     (dec_load),
    .dec_store    (dec_store),
    .dec_regwrite (dec_regwrite),
    .dec_branch   (dec_branch),
    .halt_req     (halt_req),
    .dmem_valid   (dmem_valid),
    .dmem_wen     (dmem_wen),
    .dmem_ready   (dmem_ready),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .reg_we       (reg_we),
    .state        (state),
    .halted       (halted),
    .err          (err),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ready   = 1'b0;
    dec_load     = 1'b0;
    dec_store    = 1'b0;
    dec_regwrite = 1'b0;
    dec_branch   = 1'b0;
    halt_req     = 1'b0;
    dmem_ready   = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_instret = 64'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    dec_regwrite = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++;
    if (imem_valid !== 1'b1) begin failures++; $display("FAIL reset_imem_valid got=%b exp=1", imem_valid); end
    checks++;
    if (instret !== 64'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    checks++;
    if (halted !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_flags got halted=%b err=%b exp 0/0", halted, err); end
    checks++;
    if (pc_we !== 1'b0 || reg_we !== 1'b0 || dmem_valid !== 1'b0) begin
      failures++; $display("FAIL reset_strobes got pc_we=%b reg_we=%b dmem_valid=%b exp 0", pc_we, reg_we, dmem_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_inputs();
    exp_instret = 64'd0;
  endtask

  // ALU op, zero-wait fetch; dmem_ready high but must be ignored.
  task automatic test_alu();
    logic [11:0] seq;
    seq = {3'd4, 3'd2, 3'd1, 3'd0};
    imem_ready = 1'b1; dec_regwrite = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state !== seq[3*i +: 3]) begin failures++; $display("FAIL alu_state cyc=%0d got=%0d exp=%0d", i, state, seq[3*i +: 3]); end
      checks++;
      if (ir_we !== (i == 0)) begin failures++; $display("FAIL alu_ir_we cyc=%0d got=%b", i, ir_we); end
      checks++;
      if (pc_we !== (i == 3) || reg_we !== (i == 3)) begin
        failures++; $display("FAIL alu_commit cyc=%0d got pc_we=%b reg_we=%b", i, pc_we, reg_we);
      end
      checks++;
      if (dmem_valid !== 1'b0) begin failures++; $display("FAIL alu_dmem_valid cyc=%0d got=%b exp=0", i, dmem_valid); end
      if (i == 3) begin
        checks++;
        if (pc_sel !== 1'b0) begin failures++; $display("FAIL alu_pc_sel got=%b exp=0", pc_sel); end
      end
      next_cycle();
    end
    exp_instret = exp_instret + 64'd1;
    #1;
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL alu_return_state got=%0d exp=0", state); end
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL alu_instret got=%0d exp=%0d", instret, exp_instret); end
    clear_inputs();
  endtask

  // Load right after reset, dmem_ready arriving on the 4th MEM cycle.
  task automatic test_load_wait();
    logic [23:0] seq;
    int          dv_count;
    seq = {3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    dv_count = 0;
    apply_reset();
    imem_ready = 1'b1; dec_load = 1'b1; dec_regwrite = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      dmem_ready = (c == 7);
      #1;
      checks++;
      if (state !== seq[3*(c-1) +: 3]) begin failures++; $display("FAIL load_state cyc=%0d got=%0d exp=%0d", c, state, seq[3*(c-1) +: 3]); end
      if (dmem_valid === 1'b1) dv_count++;
      checks++;
      if (dmem_wen !== 1'b0) begin failures++; $display("FAIL load_dmem_wen cyc=%0d got=%b exp=0", c, dmem_wen); end
      checks++;
      if (reg_we !== (c == 8) || pc_we !== (c == 8)) begin
        failures++; $display("FAIL load_commit cyc=%0d got reg_we=%b pc_we=%b", c, reg_we, pc_we);
      end
      next_cycle();
    end
    exp_instret = exp_instret + 64'd1;
    checks++;
    if (dv_count != 4) begin failures++; $display("FAIL load_dmem_valid_cycles got=%0d exp=4", dv_count); end
    #1;
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL load_instret got=%0d exp=%0d", instret, exp_instret); end
    clear_inputs();
  endtask

  // Store that also flags regwrite: rd must not be written.
  task automatic test_store();
    logic [14:0] seq;
    seq = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    imem_ready = 1'b1; dec_store = 1'b1; dec_regwrite = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state !== seq[3*i +: 3]) begin failures++; $display("FAIL store_state cyc=%0d got=%0d exp=%0d", i, state, seq[3*i +: 3]); end
      checks++;
      if (dmem_valid !== (i == 3) || dmem_wen !== (i == 3)) begin
        failures++; $display("FAIL store_dmem cyc=%0d got valid=%b wen=%b", i, dmem_valid, dmem_wen);
      end
      if (i == 4) begin
        checks++;
        if (reg_we !== 1'b0 || pc_we !== 1'b1 || pc_sel !== 1'b0) begin
          failures++; $display("FAIL store_wb got reg_we=%b pc_we=%b pc_sel=%b exp 0/1/0", reg_we, pc_we, pc_sel);
        end
      end
      next_cycle();
    end
    exp_instret = exp_instret + 64'd1;
    #1;
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL store_instret got=%0d exp=%0d", instret, exp_instret); end
    clear_inputs();
  endtask

  // Taken jump with link: no MEM state, pc_sel=1 at commit.
  task automatic test_branch();
    logic [11:0] seq;
    seq = {3'd4, 3'd2, 3'd1, 3'd0};
    imem_ready = 1'b1; dec_branch = 1'b1; dec_regwrite = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state !== seq[3*i +: 3]) begin failures++; $display("FAIL branch_state cyc=%0d got=%0d exp=%0d", i, state, seq[3*i +: 3]); end
      checks++;
      if (dmem_valid !== 1'b0) begin failures++; $display("FAIL branch_dmem_valid cyc=%0d got=%b exp=0", i, dmem_valid); end
      if (i == 3) begin
        checks++;
        if (pc_sel !== 1'b1 || pc_we !== 1'b1 || reg_we !== 1'b1) begin
          failures++; $display("FAIL branch_wb got pc_sel=%b pc_we=%b reg_we=%b exp 1/1/1", pc_sel, pc_we, reg_we);
        end
      end
      next_cycle();
    end
    exp_instret = exp_instret + 64'd1;
    #1;
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL branch_instret got=%0d exp=%0d", instret, exp_instret); end
    clear_inputs();
  endtask

  // Three fetch wait cycles before imem_ready.
  task automatic test_fetch_wait();
    logic [20:0] seq;
    seq = {3'd4, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    dec_regwrite = 1'b1;
    for (int i = 0; i < 7; i++) begin
      imem_ready = (i >= 3);
      #1;
      checks++;
      if (state !== seq[3*i +: 3]) begin failures++; $display("FAIL fwait_state cyc=%0d got=%0d exp=%0d", i, state, seq[3*i +: 3]); end
      checks++;
      if (imem_valid !== (i <= 3) || ir_we !== (i == 3)) begin
        failures++; $display("FAIL fwait_fetch cyc=%0d got imem_valid=%b ir_we=%b", i, imem_valid, ir_we);
      end
      next_cycle();
    end
    exp_instret = exp_instret + 64'd1;
    #1;
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL fwait_instret got=%0d exp=%0d", instret, exp_instret); end
    clear_inputs();
  endtask

  // Two ALU ops back to back: 8 cycles, exactly two commits.
  task automatic test_back_to_back();
    int commits;
    commits = 0;
    imem_ready = 1'b1; dec_regwrite = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (pc_we === 1'b1) commits++;
      next_cycle();
    end
    exp_instret = exp_instret + 64'd2;
    #1;
    checks++;
    if (commits != 2) begin failures++; $display("FAIL b2b_commits got=%0d exp=2", commits); end
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL b2b_state got=%0d exp=0", state); end
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL b2b_instret got=%0d exp=%0d", instret, exp_instret); end
    clear_inputs();
  endtask

  // ebreak: HALT is terminal and silent; async reset recovers.
  task automatic test_halt();
    imem_ready = 1'b1; halt_req = 1'b1; dec_regwrite = 1'b1; dmem_ready = 1'b1;
    next_cycle();
    #1;
    checks++;
    if (state !== 3'd1) begin failures++; $display("FAIL halt_decode_state got=%0d exp=1", state); end
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (state !== 3'd5 || halted !== 1'b1) begin
        failures++; $display("FAIL halt_hold cyc=%0d got state=%0d halted=%b exp 5/1", i, state, halted);
      end
      checks++;
      if ({imem_valid, ir_we, dmem_valid, dmem_wen, pc_we, reg_we} !== 6'b0) begin
        failures++; $display("FAIL halt_strobes cyc=%0d got=%b exp=000000", i,
                             {imem_valid, ir_we, dmem_valid, dmem_wen, pc_we, reg_we});
      end
      next_cycle();
    end
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL halt_instret got=%0d exp=%0d", instret, exp_instret); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || halted !== 1'b0) begin
      failures++; $display("FAIL halt_reset got state=%0d halted=%b exp 0/0", state, halted);
    end
    checks++;
    if (instret !== 64'd0) begin failures++; $display("FAIL halt_reset_instret got=%0d exp=0", instret); end
    apply_reset();
  endtask

  // Reset while waiting in MEM aborts the access with no commit.
  task automatic test_reset_midflight();
    imem_ready = 1'b1; dec_load = 1'b1; dec_regwrite = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    #1;
    checks++;
    if (state !== 3'd3 || dmem_valid !== 1'b1) begin
      failures++; $display("FAIL midflight_mem got state=%0d dmem_valid=%b exp 3/1", state, dmem_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || dmem_valid !== 1'b0 || pc_we !== 1'b0 || reg_we !== 1'b0) begin
      failures++; $display("FAIL midflight_abort got state=%0d dmem_valid=%b pc_we=%b reg_we=%b", state, dmem_valid, pc_we, reg_we);
    end
    checks++;
    if (instret !== 64'd0) begin failures++; $display("FAIL midflight_instret got=%0d exp=0", instret); end
    apply_reset();
  endtask

`ifdef YSYX_22040386_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state !== 3'd0 || err !== 1'b0) begin
        failures++; $display("FAIL tmo_wait cyc=%0d got state=%0d err=%b exp 0/0", i, state, err);
      end
      next_cycle();
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state !== 3'd6 || err !== 1'b1 || imem_valid !== 1'b0) begin
        failures++; $display("FAIL tmo_err cyc=%0d got state=%0d err=%b imem_valid=%b exp 6/1/0", i, state, err, imem_valid);
      end
      next_cycle();
    end
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      imem_ready = (i == 3);
      #1;
      checks++;
      if (state !== ((i == 4) ? 3'd1 : 3'd0) || err !== 1'b0) begin
        failures++; $display("FAIL tmo_ready_wins cyc=%0d got state=%0d err=%b", i, state, err);
      end
      next_cycle();
    end
    apply_reset();
  endtask
`else
  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < 300; i++) next_cycle();
    #1;
    checks++;
    if (state !== 3'd0 || err !== 1'b0 || imem_valid !== 1'b1) begin
      failures++; $display("FAIL unbounded_wait got state=%0d err=%b imem_valid=%b exp 0/0/1", state, err, imem_valid);
    end
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_branch();
    test_fetch_wait();
    test_back_to_back();
    test_halt();
    test_reset_midflight();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
